// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-ported integer register file with scoreboard bits and a
// self-clearing start-up / re-zero sequence.
//
// After reset (or a clear_i pulse) the file walks indices 1..NREGS-1 writing
// zero, one per cycle, with busy_o high. Only then does it accept writes and
// reservations. Index 0 is hardwired to zero and is always ready in RUN.
//
// Ports:
//   clk_i              clock, all state changes on the rising edge
//   rst_i              asynchronous active-high reset
//   clear_i            pulse: re-zero the whole file (taken in RUN only)
//   we_i/selRd_i/rd_i  write port
//   reserve_i/selRes_i mark a register pending (in-flight producer)
//   selRs1_i/selRs2_i  read indices
//   rs1_o/rs2_o        combinational read data
//   rs1Rdy_o/rs2Rdy_o  read index has no pending producer
//   busy_o             clear sequence in progress
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a RUN write is forwarded to a read of the
//                      same index in the same cycle.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] selRd_i,
    input  logic [XLEN-1:0]          rd_i,
    input  logic                     reserve_i,
    input  logic [$clog2(NREGS)-1:0] selRes_i,
    input  logic [$clog2(NREGS)-1:0] selRs1_i,
    input  logic [$clog2(NREGS)-1:0] selRs2_i,
    output logic [XLEN-1:0]          rs1_o,
    output logic [XLEN-1:0]          rs2_o,
    output logic                     rs1Rdy_o,
    output logic                     rs2Rdy_o,
    output logic                     busy_o
);

    localparam int unsigned SELW = $clog2(NREGS);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [NREGS-1:0]  pending_q;

    logic              run;
    logic              wr_en;
    logic              res_en;

    // Qualified requests: nothing but reads is honoured outside RUN, and a
    // clear request in RUN swallows the write issued alongside it.
    assign run    = (state_q == RUN);
    assign wr_en  = run && we_i && !clear_i && (selRd_i != '0);
    assign res_en = run && reserve_i && !clear_i && (selRes_i != '0);
    assign busy_o = (state_q == CLEAR);

    // State and clear-counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= SELW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: CLEAR walks the counter up to NREGS-1, then RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                if (cnt_q == SELW'(NREGS - 1)) begin
                    state_d = RUN;
                    cnt_d   = SELW'(1);
                end else begin
                    cnt_d   = cnt_q + SELW'(1);
                end
            end
            RUN: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = SELW'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = SELW'(1);
            end
        endcase
    end

    // Storage: no reset on the data, the clear sequence zeroes it instead.
    always_ff @(posedge clk_i) begin
        regs_q[0] <= '0;
        if (state_q == CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[selRd_i] <= rd_i;
        end
    end

    // Pending bits: a write retires the producer, a reservation in the same
    // cycle is applied last so it wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else if (!run || clear_i) begin
            pending_q <= '0;
        end else begin
            if (wr_en) begin
                pending_q[selRd_i] <= 1'b0;
            end
            if (res_en) begin
                pending_q[selRes_i] <= 1'b1;
            end
        end
    end

    // Read port 1.
    always_comb begin
        rs1_o    = '0;
        rs1Rdy_o = 1'b0;
        if (run) begin
            if (selRs1_i == '0) begin
                rs1Rdy_o = 1'b1;
            end else begin
                rs1_o    = regs_q[selRs1_i];
                rs1Rdy_o = !pending_q[selRs1_i];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (selRd_i == selRs1_i)) begin
                    rs1_o    = rd_i;
                    rs1Rdy_o = !(res_en && (selRes_i == selRs1_i));
                end
`endif
            end
        end
    end

    // Read port 2.
    always_comb begin
        rs2_o    = '0;
        rs2Rdy_o = 1'b0;
        if (run) begin
            if (selRs2_i == '0) begin
                rs2Rdy_o = 1'b1;
            end else begin
                rs2_o    = regs_q[selRs2_i];
                rs2Rdy_o = !pending_q[selRs2_i];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (selRd_i == selRs2_i)) begin
                    rs2_o    = rd_i;
                    rs2Rdy_o = !(res_en && (selRes_i == selRs2_i));
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (XLEN=32, NREGS=32).
// Directed vector table for the RUN-mode read/write/reserve rules, hand-written
// sequences for reset, clear and reset-during-clear, then random traffic
// against a behavioural model.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int NR = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        we_i;
    logic [4:0]  selRd_i;
    logic [31:0] rd_i;
    logic        reserve_i;
    logic [4:0]  selRes_i;
    logic [4:0]  selRs1_i;
    logic [4:0]  selRs2_i;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;
    logic        rs1Rdy_o;
    logic        rs2Rdy_o;
    logic        busy_o;

    regfile_mp #(.XLEN(32), .NREGS(NR)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .we_i     (we_i),
        .selRd_i  (selRd_i),
        .rd_i     (rd_i),
        .reserve_i(reserve_i),
        .selRes_i (selRes_i),
        .selRs1_i (selRs1_i),
        .selRs2_i (selRs2_i),
        .rs1_o    (rs1_o),
        .rs2_o    (rs2_o),
        .rs1Rdy_o (rs1Rdy_o),
        .rs2Rdy_o (rs2Rdy_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Behavioural model: number of clear writes still to come, register
    // contents and pending flags.
    int          clear_left;
    logic [31:0] m_regs [NR];
    bit          m_pend [NR];

    task automatic model_reset();
        clear_left = NR - 1;
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    endtask

    // Apply one rising edge to the model using the current inputs.
    task automatic model_edge();
        if (rst_i) begin
            model_reset();
        end else if (clear_left > 0) begin
            m_regs[NR - clear_left] = 32'h0;
            clear_left--;
            for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        end else if (clear_i) begin
            model_reset();
        end else begin
            if (we_i && selRd_i != 5'd0) begin
                m_regs[selRd_i] = rd_i;
                m_pend[selRd_i] = 1'b0;
            end
            if (reserve_i && selRes_i != 5'd0) m_pend[selRes_i] = 1'b1;
        end
    endtask

    task automatic exp_read(input logic [4:0] sel, output logic [31:0] d, output logic r);
        d = 32'h0;
        r = 1'b0;
        if (clear_left == 0) begin
            if (sel == 5'd0) begin
                r = 1'b1;
            end else if (BYP && we_i && !clear_i && selRd_i == sel) begin
                d = rd_i;
                r = !(reserve_i && selRes_i == sel);
            end else begin
                d = m_regs[sel];
                r = !m_pend[sel];
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic check_outputs(input string name);
        logic [31:0] d1, d2;
        logic        r1, r2;
        #1;
        exp_read(selRs1_i, d1, r1);
        exp_read(selRs2_i, d2, r2);
        chk({name, "_rs1"},    rs1_o,           d1);
        chk({name, "_rs1rdy"}, 32'(rs1Rdy_o),   32'(r1));
        chk({name, "_rs2"},    rs2_o,           d2);
        chk({name, "_rs2rdy"}, 32'(rs2Rdy_o),   32'(r2));
        chk({name, "_busy"},   32'(busy_o),     32'(clear_left > 0));
    endtask

    // Count cycles with busy_o high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!busy_o) break;
            n++;
            tick();
        end
    endtask

    task automatic idle_inputs();
        clear_i   = 1'b0;
        we_i      = 1'b0;
        reserve_i = 1'b0;
        selRd_i   = 5'd0;
        rd_i      = 32'h0;
        selRes_i  = 5'd0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  sel_rd;
        logic [31:0] rd;
        logic        res;
        logic [4:0]  sel_res;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1;
        logic        r1;
        logic [31:0] e2;
        logic        r2;
    } vec_t;

    vec_t vt [12];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Directed RUN vectors, starting from a freshly cleared file.
        vt[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 5'd0,
                   BYP ? 32'hDEADBEEF : 32'h0, 1'b1, 32'h0, 1'b1};
        vt[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                   32'hDEADBEEF, 1'b1, 32'h0, 1'b1};
        vt[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd0,
                   32'hDEADBEEF, 1'b1, 32'h0, 1'b1};
        vt[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                   32'h0, 1'b1, 32'h0, 1'b1};
        vt[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7,
                   32'h0, 1'b1, 32'hDEADBEEF, 1'b1};
        vt[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                   32'h0, 1'b0, 32'h0, 1'b1};
        vt[6]  = '{1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 5'd3, 5'd0,
                   BYP ? 32'hA5 : 32'h0, BYP, 32'h0, 1'b1};
        vt[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                   32'hA5, 1'b1, 32'h0, 1'b1};
        vt[8]  = '{1'b1, 5'd3, 32'h5A, 1'b1, 5'd3, 5'd3, 5'd0,
                   BYP ? 32'h5A : 32'hA5, !BYP, 32'h0, 1'b1};
        vt[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                   32'h5A, 1'b0, 32'h0, 1'b1};
        vt[10] = '{1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 5'd3, 5'd7,
                   BYP ? 32'h77 : 32'h5A, BYP, 32'hDEADBEEF, 1'b1};
        vt[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                   32'h77, 1'b1, 32'h77, 1'b1};

        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;

        // Reset with a write held on the port the whole time.
        rst_i     = 1'b1;
        model_reset();
        idle_inputs();
        we_i      = 1'b1;
        selRd_i   = 5'd5;
        rd_i      = 32'hFFFFFFFF;
        selRs1_i  = 5'd5;
        selRs2_i  = 5'd9;
        tick();
        tick();
        chk("reset_busy", 32'(busy_o), 32'h1);
        chk("reset_rdy",  32'(rs1Rdy_o), 32'h0);
        check_outputs("reset");
        rst_i = 1'b0;

        count_busy(n);
        chk("startup_busy_cycles", 32'(n), 32'd31);
        we_i = 1'b0;
        #1;
        chk("x5_zero_after_clear", rs1_o, 32'h0);
        chk("x5_rdy_after_clear",  32'(rs1Rdy_o), 32'h1);
        we_i = 1'b1;
        tick();
        we_i = 1'b0;
        #1;
        chk("x5_written_in_run", rs1_o, 32'hFFFFFFFF);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            we_i      = vt[i].we;
            selRd_i   = vt[i].sel_rd;
            rd_i      = vt[i].rd;
            reserve_i = vt[i].res;
            selRes_i  = vt[i].sel_res;
            selRs1_i  = vt[i].rs1;
            selRs2_i  = vt[i].rs2;
            #1;
            chk($sformatf("vec%0d_rs1", i),    rs1_o,         vt[i].e1);
            chk($sformatf("vec%0d_rs1rdy", i), 32'(rs1Rdy_o), 32'(vt[i].r1));
            chk($sformatf("vec%0d_rs2", i),    rs2_o,         vt[i].e2);
            chk($sformatf("vec%0d_rs2rdy", i), 32'(rs2Rdy_o), 32'(vt[i].r2));
            tick();
        end

        // Clear request with a simultaneous write to x9; x4 left pending.
        idle_inputs();
        reserve_i = 1'b1;
        selRes_i  = 5'd4;
        tick();
        idle_inputs();
        selRs1_i  = 5'd4;
        #1;
        chk("x4_pending", 32'(rs1Rdy_o), 32'h0);
        clear_i = 1'b1;
        we_i    = 1'b1;
        selRd_i = 5'd9;
        rd_i    = 32'h99999999;
        tick();
        idle_inputs();
        #1;
        chk("clear_busy_now", 32'(busy_o), 32'h1);
        chk("clear_read_zero", rs1_o, 32'h0);
        chk("clear_rdy_zero",  32'(rs1Rdy_o), 32'h0);
        count_busy(n);
        chk("clear_busy_cycles", 32'(n), 32'd31);
        for (int i = 1; i < NR; i++) begin
            selRs1_i = 5'(i);
            selRs2_i = 5'(NR - i);
            #1;
            chk($sformatf("swept_x%0d", i),     rs1_o, 32'h0);
            chk($sformatf("swept_rdy_x%0d", i), 32'(rs1Rdy_o), 32'h1);
            chk($sformatf("swept2_x%0d", NR - i), rs2_o, 32'h0);
            tick();
        end

        // Reset part-way through a clear sequence (counter at 15).
        idle_inputs();
        we_i    = 1'b1;
        selRd_i = 5'd20;
        rd_i    = 32'h13579BDF;
        tick();
        idle_inputs();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("midreset_busy", 32'(busy_o), 32'h1);
        tick();
        rst_i = 1'b0;
        count_busy(n);
        chk("midreset_busy_cycles", 32'(n), 32'd31);
        selRs1_i = 5'd20;
        check_outputs("after_midreset");

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            logic [4:0] m;
            m = ($urandom_range(0, 1) != 0) ? 5'd7 : 5'd31;
            clear_i   = ($urandom_range(0, 127) == 0);
            we_i      = ($urandom_range(0, 1) != 0);
            selRd_i   = 5'($urandom) & m;
            rd_i      = $urandom;
            reserve_i = ($urandom_range(0, 2) == 0);
            selRes_i  = 5'($urandom) & m;
            selRs1_i  = 5'($urandom) & m;
            selRs2_i  = 5'($urandom) & m;
            check_outputs("rand");
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: data width in bits, minimum 8.
REQ-002 Parameter NREGS, default 32: register count, power of two, minimum 4; index 0 is hardwired zero.
REQ-003 Local parameter SELW = clog2(NREGS): select width.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 clear_i  in  1  request re-zeroing of all registers (pulse).
REQ-007 we_i  in  1  write enable.
REQ-008 selRd_i  in  SELW  write index.
REQ-009 rd_i  in  XLEN  write data.
REQ-010 reserve_i  in  1  mark a register pending (in-flight producer).
REQ-011 selRes_i  in  SELW  index to reserve.
REQ-012 selRs1_i, selRs2_i  in  SELW  read indices.
REQ-013 rs1_o, rs2_o  out  XLEN  combinational read data.
REQ-014 rs1Rdy_o, rs2Rdy_o  out  1  read index not pending.
REQ-015 busy_o  out  1  clear sequence in progress.

Function
REQ-016 FSM states: CLEAR, RUN. CLEAR -> RUN after the write to index NREGS-1. RUN -> CLEAR on clear_i sampled high.
REQ-017 In CLEAR, the counter starts at 1 and writes zero to one register per cycle, ascending: NREGS-1 cycles total. busy_o is high for exactly those cycles.
REQ-018 In CLEAR:
  - we_i, reserve_i and clear_i are ignored.
  - rs1_o and rs2_o read 0.
  - rs1Rdy_o and rs2Rdy_o read 0.
  - All pending bits are cleared on entry.
REQ-019 In RUN, we_i high with selRd_i != 0 writes rd_i at the clock edge; writes to index 0 are discarded.
REQ-020 A read of index 0 always returns 0 with ready 1. Any other index returns the stored value combinationally.
REQ-021 Pending bits:
  - reserve_i with selRes_i != 0 sets pending[selRes_i].
  - A RUN write clears pending[selRd_i].
  - If reserve and write target the same index in one cycle, the bit ends set (reserve wins).
REQ-022 rsNRdy_o = !pending[selRsN_i] in RUN.
REQ-023 clear_i asserted in RUN with we_i in the same cycle: the write is discarded and CLEAR is entered next cycle.

Reset
REQ-024 rst_i high asynchronously:
  - forces state CLEAR, counter 1, busy_o 1;
  - clears all pending bits;
  - leaves register contents to the clear sequence.
REQ-025 The first clear write occurs on the first rising edge after rst_i deasserts. RUN is entered NREGS-1 edges later.
REQ-026 rst_i asserted mid-sequence restarts the sequence at index 1.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN, when defined, enables same-cycle write forwarding in RUN. When we_i is high and selRd_i == selRsN_i != 0:
  - rsN_o = rd_i;
  - rsNRdy_o = 1, unless reserve_i targets the same index that cycle.
REQ-028 Without REGFILE_BYPASS_EN, reads return the pre-write stored value and the pre-write pending state. The written value is visible from the next cycle.

Verification
REQ-029 NREGS=32: deassert rst_i, hold we_i=1, selRd_i=5, rd_i=0xFFFFFFFF -> busy_o high 31 cycles; reg 5 reads 0 after busy_o falls; the write occurs only once busy_o is low.
REQ-030 RUN: write 0xDEADBEEF to x7, read selRs1_i=7 in the same cycle -> 0xDEADBEEF with BYPASS_EN, old value without; 0xDEADBEEF next cycle in both builds.
REQ-031 Write 0x12345678 to x0, then read selRs2_i=0 -> rs2_o=0, rs2Rdy_o=1.
REQ-032 Reserve x3, then read x3 -> rs1Rdy_o=0. Write x3 with data 0xA5 -> rs1Rdy_o=1 the next cycle. Reserve and write x3 in the same cycle -> rs1Rdy_o stays 0.
REQ-033 Pulse clear_i with we_i to x9 in the same cycle -> x9 not written; busy_o high 31 cycles; all registers read 0 afterwards.
REQ-034 Assert rst_i at clear counter 15 -> sequence restarts; busy_o stays high 31 cycles after deassert.
